// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle CPU control unit.
// Holds the FSM state encoding, the opcode/funct constants it decodes, the ULA
// operation codes and the datapath mux select values, plus the packed bundle
// of registered control outputs.
package cpu_ctrl_pkg;

    localparam int unsigned CNT_W = 3;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EX_R     = 4'd3,
        S_EX_ADDI  = 4'd4,
        S_WB_ALU   = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_EXCP     = 4'd12
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;

    // ULA operation codes
    localparam logic [2:0] ULA_LOAD = 3'b000;
    localparam logic [2:0] ULA_ADD  = 3'b001;
    localparam logic [2:0] ULA_SUB  = 3'b010;
    localparam logic [2:0] ULA_AND  = 3'b011;

    // Memory address mux
    localparam logic [2:0] MEM_SEL_PC     = 3'b000;
    localparam logic [2:0] MEM_SEL_ALUOUT = 3'b001;

    // ULA operand A mux
    localparam logic       A_SEL_PC = 1'b0;
    localparam logic       A_SEL_A  = 1'b1;

    // ULA operand B mux
    localparam logic [1:0] B_SEL_B       = 2'b00;
    localparam logic [1:0] B_SEL_FOUR    = 2'b01;
    localparam logic [1:0] B_SEL_SEXT    = 2'b10;
    localparam logic [1:0] B_SEL_SEXT_SH = 2'b11;

    // Register file write address mux
    localparam logic [1:0] WREG_RT = 2'b00;
    localparam logic [1:0] WREG_RD = 2'b01;

    // Register file write data mux
    localparam logic [2:0] WDATA_ALUOUT = 3'b000;
    localparam logic [2:0] WDATA_MEM    = 3'b001;

    // PC source mux
    localparam logic [2:0] PC_SRC_ULA    = 3'b000;
    localparam logic [2:0] PC_SRC_ALUOUT = 3'b001;
    localparam logic [2:0] PC_SRC_JUMP   = 3'b010;
    localparam logic [2:0] PC_SRC_EXC    = 3'b100;

    // Registered control outputs
    typedef struct packed {
        logic       pc_w;
        logic       mem_w;
        logic       ir_w;
        logic       rb_w;
        logic       ab_w;
        logic       alu_w;
        logic       epc_w;
        logic [2:0] ula_c;
        logic [2:0] sel_mem;
        logic       sel_a;
        logic [1:0] sel_b;
        logic [1:0] sel_wreg;
        logic [2:0] sel_wdata;
        logic [2:0] sel_pc;
        logic       cause;
    } ctrl_t;

    // True for the R-type functions the datapath implements
    function automatic logic r_supported(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND);
    endfunction

    // ULA operation for a supported R-type function
    function automatic logic [2:0] funct_to_ula(input logic [5:0] fn);
        logic [2:0] op;
        op = ULA_ADD;
        if (fn == FN_SUB) op = ULA_SUB;
        if (fn == FN_AND) op = ULA_AND;
        return op;
    endfunction

endpackage

// File: rtl/control_unit.sv
// Multicycle control FSM for the MIPS-subset datapath.
// Sequences fetch/decode/execute/memory/writeback and raises overflow and
// invalid-opcode exceptions through EPC.
// Parameters: MEM_WAIT extra wait cycles per memory read (0..7),
//             EXC_VECTOR exception handler address.
// Ports: clk, reset (async, active-low); OPCODE/funct from IR; Of/Eq ULA flags;
//        write enables PC_w, MEM_w, IR_w, RB_w, AB_w, ALU_w, EPC_w; ULA_c;
//        mux selects M_selector_*; exc_addr; cause (0 overflow, 1 invalid).
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT   = 1,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_00FC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  OPCODE,
    input  logic [5:0]  funct,
    input  logic        Of,
    input  logic        Eq,
    output logic        PC_w,
    output logic        MEM_w,
    output logic        IR_w,
    output logic        RB_w,
    output logic        AB_w,
    output logic        ALU_w,
    output logic        EPC_w,
    output logic [2:0]  ULA_c,
    output logic [2:0]  M_selector_Memory,
    output logic        M_selector_A,
    output logic [1:0]  M_selector_B,
    output logic [1:0]  M_selector_writereg,
    output logic [2:0]  M_selector_WDATA,
    output logic [2:0]  M_selector_ALUOut,
    output logic [31:0] exc_addr,
    output logic        cause
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    ctrl_t              ctrl_q, ctrl_d;
    logic               branch_take;

    // State, wait counter and output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Next state, then the outputs belonging to that state (registered Moore)
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = '0;

        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH: begin
                if (cnt_q == CNT_LAST) state_d = S_DECODE;
                else                   cnt_d   = cnt_q + CNT_W'(1);
            end
            S_DECODE: begin
                if (OPCODE == OP_RTYPE && r_supported(funct)) state_d = S_EX_R;
                else if (OPCODE == OP_ADDI)                   state_d = S_EX_ADDI;
                else if (OPCODE == OP_LW || OPCODE == OP_SW)  state_d = S_MEM_ADDR;
                else if (OPCODE == OP_BEQ)                    state_d = S_BRANCH;
                else if (OPCODE == OP_J)                      state_d = S_JUMP;
                else                                          state_d = S_EXCP;
            end
            // Logical AND cannot overflow, so Of is ignored for it
            S_EX_R:    state_d = (Of && funct != FN_AND) ? S_EXCP : S_WB_ALU;
            S_EX_ADDI: state_d = Of ? S_EXCP : S_WB_ALU;
            S_MEM_ADDR: state_d = (OPCODE == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (cnt_q == CNT_LAST) state_d = S_WB_MEM;
                else                   cnt_d   = cnt_q + CNT_W'(1);
            end
            S_WB_ALU, S_WB_MEM, S_MEM_WR,
            S_BRANCH, S_JUMP, S_EXCP: state_d = S_FETCH;
            default:  state_d = S_RESET;
        endcase

        // Counted states always start from zero
        if ((state_d == S_FETCH || state_d == S_MEM_RD) && state_d != state_q)
            cnt_d = '0;

        case (state_d)
            S_FETCH: begin
                ctrl_d.sel_mem = MEM_SEL_PC;
                ctrl_d.sel_a   = A_SEL_PC;
                ctrl_d.sel_b   = B_SEL_FOUR;
                ctrl_d.ula_c   = ULA_ADD;
                if (cnt_d == CNT_LAST) begin
                    ctrl_d.ir_w   = 1'b1;
                    ctrl_d.pc_w   = 1'b1;
                    ctrl_d.sel_pc = PC_SRC_ULA;
                end
            end
            S_DECODE: begin
                // ALUOut <= PC + (signext << 2): branch target ready for BRANCH
                ctrl_d.ab_w  = 1'b1;
                ctrl_d.alu_w = 1'b1;
                ctrl_d.sel_a = A_SEL_PC;
                ctrl_d.sel_b = B_SEL_SEXT_SH;
                ctrl_d.ula_c = ULA_ADD;
            end
            S_EX_R: begin
                ctrl_d.sel_a = A_SEL_A;
                ctrl_d.sel_b = B_SEL_B;
                ctrl_d.ula_c = funct_to_ula(funct);
                ctrl_d.alu_w = 1'b1;
            end
            S_EX_ADDI, S_MEM_ADDR: begin
                ctrl_d.sel_a = A_SEL_A;
                ctrl_d.sel_b = B_SEL_SEXT;
                ctrl_d.ula_c = ULA_ADD;
                ctrl_d.alu_w = 1'b1;
            end
            S_WB_ALU: begin
                ctrl_d.rb_w      = 1'b1;
                ctrl_d.sel_wdata = WDATA_ALUOUT;
                ctrl_d.sel_wreg  = (state_q == S_EX_R) ? WREG_RD : WREG_RT;
            end
            S_MEM_RD: ctrl_d.sel_mem = MEM_SEL_ALUOUT;
            S_WB_MEM: begin
                ctrl_d.rb_w      = 1'b1;
                ctrl_d.sel_wreg  = WREG_RT;
                ctrl_d.sel_wdata = WDATA_MEM;
            end
            S_MEM_WR: begin
                ctrl_d.sel_mem = MEM_SEL_ALUOUT;
                ctrl_d.mem_w   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_d.sel_a = A_SEL_A;
                ctrl_d.sel_b = B_SEL_B;
                ctrl_d.ula_c = ULA_SUB;
            end
            S_JUMP: begin
                ctrl_d.pc_w   = 1'b1;
                ctrl_d.sel_pc = PC_SRC_JUMP;
            end
            S_EXCP: begin
                // EPC <= PC - 4; arrival straight from DECODE means invalid opcode
                ctrl_d.sel_a  = A_SEL_PC;
                ctrl_d.sel_b  = B_SEL_FOUR;
                ctrl_d.ula_c  = ULA_SUB;
                ctrl_d.epc_w  = 1'b1;
                ctrl_d.pc_w   = 1'b1;
                ctrl_d.sel_pc = PC_SRC_EXC;
                ctrl_d.cause  = (state_q == S_DECODE);
            end
            default: ctrl_d = '0;
        endcase
    end

    // Eq is only known while BRANCH compares A and B, so the taken-branch PC write
    // is the one output term that follows the flag within the cycle
    assign branch_take = (state_q == S_BRANCH) && Eq;

    assign PC_w                = ctrl_q.pc_w | branch_take;
    assign MEM_w               = ctrl_q.mem_w;
    assign IR_w                = ctrl_q.ir_w;
    assign RB_w                = ctrl_q.rb_w;
    assign AB_w                = ctrl_q.ab_w;
    assign ALU_w               = ctrl_q.alu_w;
    assign EPC_w               = ctrl_q.epc_w;
    assign ULA_c               = ctrl_q.ula_c;
    assign M_selector_Memory   = ctrl_q.sel_mem;
    assign M_selector_A        = ctrl_q.sel_a;
    assign M_selector_B        = ctrl_q.sel_b;
    assign M_selector_writereg = ctrl_q.sel_wreg;
    assign M_selector_WDATA    = ctrl_q.sel_wdata;
    assign M_selector_ALUOut   = ctrl_q.sel_pc | (branch_take ? PC_SRC_ALUOUT : 3'b000);
    assign exc_addr            = EXC_VECTOR;
    assign cause               = ctrl_q.cause;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: each instruction is expanded into its
// expected per-cycle output trace, queued as it is driven, and a monitor
// compares every cycle on the falling edge.
module tb_control_unit;

    localparam int unsigned MW = 3;
    localparam logic [31:0] EV = 32'h8000_0180;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_ADDI  = 6'b001000;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_J     = 6'b000010;
    localparam logic [5:0] T_ADD   = 6'b100000;
    localparam logic [5:0] T_SUB   = 6'b100010;
    localparam logic [5:0] T_AND   = 6'b100100;

    typedef struct packed {
        logic       pc_w;
        logic       mem_w;
        logic       ir_w;
        logic       rb_w;
        logic       ab_w;
        logic       alu_w;
        logic       epc_w;
        logic [2:0] ula;
        logic [2:0] msm;
        logic       msa;
        logic [1:0] msb;
        logic [1:0] mwr;
        logic [2:0] mwd;
        logic [2:0] mpc;
        logic       cause;
    } out_t;

    typedef struct {
        out_t e;
        int   id;
    } item_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  OPCODE, funct;
    logic        Of, Eq;
    logic        PC_w, MEM_w, IR_w, RB_w, AB_w, ALU_w, EPC_w;
    logic [2:0]  ULA_c, M_selector_Memory, M_selector_WDATA, M_selector_ALUOut;
    logic        M_selector_A;
    logic [1:0]  M_selector_B, M_selector_writereg;
    logic [31:0] exc_addr;
    logic        cause;

    item_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    cur_id = 0;

    control_unit #(.MEM_WAIT(MW), .EXC_VECTOR(EV)) dut (
        .clk                 (clk),
        .reset               (reset),
        .OPCODE              (OPCODE),
        .funct               (funct),
        .Of                  (Of),
        .Eq                  (Eq),
        .PC_w                (PC_w),
        .MEM_w               (MEM_w),
        .IR_w                (IR_w),
        .RB_w                (RB_w),
        .AB_w                (AB_w),
        .ALU_w               (ALU_w),
        .EPC_w               (EPC_w),
        .ULA_c               (ULA_c),
        .M_selector_Memory   (M_selector_Memory),
        .M_selector_A        (M_selector_A),
        .M_selector_B        (M_selector_B),
        .M_selector_writereg (M_selector_writereg),
        .M_selector_WDATA    (M_selector_WDATA),
        .M_selector_ALUOut   (M_selector_ALUOut),
        .exc_addr            (exc_addr),
        .cause               (cause)
    );

    always #5 clk = ~clk;

    function automatic out_t actual();
        out_t a;
        a.pc_w  = PC_w;   a.mem_w = MEM_w; a.ir_w  = IR_w;  a.rb_w = RB_w;
        a.ab_w  = AB_w;   a.alu_w = ALU_w; a.epc_w = EPC_w;
        a.ula   = ULA_c;  a.msm   = M_selector_Memory;      a.msa  = M_selector_A;
        a.msb   = M_selector_B;            a.mwr   = M_selector_writereg;
        a.mwd   = M_selector_WDATA;        a.mpc   = M_selector_ALUOut;
        a.cause = cause;
        return a;
    endfunction

    function automatic logic rbit();
        return logic'($urandom_range(0, 1));
    endfunction

    // Monitor: one expected record per clock cycle
    always @(negedge clk) begin
        item_t it;
        out_t  a;
        if (sb.size() > 0) begin
            it = sb.pop_front();
            a  = actual();
            checks++;
            if (a !== it.e) begin
                errors++;
                $display("FAIL cycle instr=%0d got=%h expected=%h (pcw%b memw%b irw%b rbw%b abw%b aluw%b epcw%b ula%h pcsrc%h cause%b)",
                         it.id, a, it.e, it.e.pc_w, it.e.mem_w, it.e.ir_w, it.e.rb_w,
                         it.e.ab_w, it.e.alu_w, it.e.epc_w, it.e.ula, it.e.mpc, it.e.cause);
            end
        end
    end

    // Drive one cycle's flag inputs and queue what the DUT should show in it
    task automatic cyc(input out_t e, input logic of_v, input logic eq_v);
        @(posedge clk);
        #1;
        Of = of_v;
        Eq = eq_v;
        sb.push_back('{e: e, id: cur_id});
    endtask

    task automatic excp(input logic c);
        out_t e;
        e = '0; e.msb = 2'b01; e.ula = 3'b010; e.epc_w = 1'b1; e.pc_w = 1'b1;
        e.mpc = 3'b100; e.cause = c;
        cyc(e, rbit(), rbit());
    endtask

    task automatic addr_calc();
        out_t e;
        e = '0; e.msa = 1'b1; e.msb = 2'b10; e.ula = 3'b001; e.alu_w = 1'b1;
        cyc(e, rbit(), rbit());
    endtask

    // Reference behaviour of one instruction, cycle by cycle
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic ovf, input logic eq);
        out_t e;
        logic r_ok;
        cur_id++;
        for (int k = 0; k <= int'(MW); k++) begin
            e = '0; e.msb = 2'b01; e.ula = 3'b001;
            if (k == int'(MW)) begin e.ir_w = 1'b1; e.pc_w = 1'b1; end
            cyc(e, rbit(), rbit());
            if (k == 0) begin OPCODE = op; funct = fn; end
        end
        e = '0; e.ab_w = 1'b1; e.alu_w = 1'b1; e.msb = 2'b11; e.ula = 3'b001;
        cyc(e, rbit(), rbit());

        r_ok = (op == T_RTYPE) && (fn == T_ADD || fn == T_SUB || fn == T_AND);
        if (r_ok || op == T_ADDI) begin
            e = '0; e.msa = 1'b1; e.alu_w = 1'b1;
            if (r_ok) begin
                e.msb = 2'b00;
                e.ula = (fn == T_ADD) ? 3'b001 : (fn == T_SUB) ? 3'b010 : 3'b011;
            end else begin
                e.msb = 2'b10;
                e.ula = 3'b001;
            end
            cyc(e, ovf, rbit());
            if (ovf && !(r_ok && fn == T_AND)) begin
                excp(1'b0);
            end else begin
                e = '0; e.rb_w = 1'b1; e.mwr = r_ok ? 2'b01 : 2'b00;
                cyc(e, rbit(), rbit());
            end
        end else if (op == T_LW) begin
            addr_calc();
            for (int k = 0; k <= int'(MW); k++) begin
                e = '0; e.msm = 3'b001;
                cyc(e, rbit(), rbit());
            end
            e = '0; e.rb_w = 1'b1; e.mwd = 3'b001;
            cyc(e, rbit(), rbit());
        end else if (op == T_SW) begin
            addr_calc();
            e = '0; e.msm = 3'b001; e.mem_w = 1'b1;
            cyc(e, rbit(), rbit());
        end else if (op == T_BEQ) begin
            e = '0; e.msa = 1'b1; e.ula = 3'b010; e.pc_w = eq;
            e.mpc = eq ? 3'b001 : 3'b000;
            cyc(e, rbit(), eq);
        end else if (op == T_J) begin
            e = '0; e.pc_w = 1'b1; e.mpc = 3'b010;
            cyc(e, rbit(), rbit());
        end else begin
            excp(1'b1);
        end
    endtask

    // Asynchronous reset in the middle of the last cycle of an instruction
    task automatic abort();
        out_t z;
        z = '0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (actual() !== z) begin
            errors++;
            $display("FAIL async_abort got=%h expected=%h", actual(), z);
        end
        cyc(z, rbit(), rbit());
        cyc(z, rbit(), rbit());
        reset = 1'b1;
    endtask

    initial begin
        out_t        z;
        logic [5:0]  op_tab[9];
        logic [5:0]  fn_tab[4];
        logic [5:0]  op, fn;
        z = '0;
        reset = 1'b0; OPCODE = '0; funct = '0; Of = 1'b0; Eq = 1'b0;
        op_tab = '{T_RTYPE, T_RTYPE, T_RTYPE, T_ADDI, T_LW, T_SW, T_BEQ, T_J, 6'b111111};
        fn_tab = '{T_ADD, T_SUB, T_AND, 6'b000000};

        repeat (3) cyc(z, rbit(), rbit());
        reset = 1'b1;

        checks++;
        if (exc_addr !== EV) begin
            errors++;
            $display("FAIL exc_addr got=%h expected=%h", exc_addr, EV);
        end

        // Directed cases
        run_instr(T_RTYPE, T_ADD, 1'b0, 1'b0);
        run_instr(T_ADDI,  T_ADD, 1'b1, 1'b0);
        run_instr(T_LW,    T_ADD, 1'b0, 1'b0);
        run_instr(T_BEQ,   T_ADD, 1'b0, 1'b0);
        run_instr(T_BEQ,   T_ADD, 1'b0, 1'b1);
        run_instr(T_J,     T_ADD, 1'b0, 1'b1);
        run_instr(6'b111111, T_ADD, 1'b0, 1'b0);
        run_instr(T_RTYPE, T_SUB, 1'b1, 1'b0);
        run_instr(T_RTYPE, T_AND, 1'b1, 1'b0);
        run_instr(T_RTYPE, 6'b000000, 1'b0, 1'b0);
        run_instr(T_ADDI,  T_ADD, 1'b0, 1'b0);
        run_instr(T_SW,    T_ADD, 1'b0, 1'b0);
        abort();
        run_instr(T_BEQ,   T_ADD, 1'b0, 1'b1);
        abort();
        run_instr(T_RTYPE, T_ADD, 1'b0, 1'b0);

        // Randomized instruction mix
        for (int n = 0; n < 80; n++) begin
            op = op_tab[$urandom_range(0, 8)];
            if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 63));
            fn = fn_tab[$urandom_range(0, 3)];
            if (fn == 6'b000000) fn = 6'($urandom_range(0, 63));
            run_instr(op, fn, rbit(), rbit());
            if ($urandom_range(0, 11) == 0) abort();
        end

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
